// File: rtl/ir_nec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ir_nec_pkg
// Description : Shared NEC IR timing constants, state encoding and scan codes
//               for the IR transmitter and receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package ir_nec_pkg;

    // Timing in 35 us slow ticks at a 50 MHz clock
    localparam int TICK_DIV     = 1750;
    localparam int LEAD_MARK    = 257;
    localparam int LEAD_SPACE   = 128;
    localparam int BIT_MARK     = 16;
    localparam int ZERO_SPACE   = 16;
    localparam int ONE_SPACE    = 48;
    localparam int GAP_TICKS    = 1143;
    localparam int CARRIER_HALF = 658;

    // Segment counter must hold GAP_TICKS-1, the longest segment
    localparam int SEG_W        = 11;
    localparam int FRAME_BITS   = 32;

    typedef logic [2:0] state_t;
    localparam state_t c_ST_IDLE   = 3'd0;
    localparam state_t c_ST_LEAD_M = 3'd1;
    localparam state_t c_ST_LEAD_S = 3'd2;
    localparam state_t c_ST_BIT_M  = 3'd3;
    localparam state_t c_ST_BIT_S  = 3'd4;
    localparam state_t c_ST_STOP_M = 3'd5;
    localparam state_t c_ST_GAP    = 3'd6;

    localparam logic [7:0] CHANNEL_MINUS = 8'hA2;
    localparam logic [7:0] CHANNEL       = 8'h62;
    localparam logic [7:0] CHANNEL_PLUS  = 8'hE2;

    function automatic logic [31:0] nec_frame(input logic [7:0] a, input logic [7:0] c);
        return {a, ~a, c, ~c};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ir_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : ir_tick_gen
// Description : Slow-tick prescaler; one-cycle tick every TICK_DIV clocks,
//               with synchronous clear to phase-align to a segment start.
// Revision    : 1.0 - initial release
// ============================================================================
module ir_tick_gen #(
    parameter int TICK_DIV = 1750
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TICK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/ir_nec_tx.sv
`default_nettype none
// ============================================================================
// Module      : ir_nec_tx
// Description : NEC IR frame transmitter: leader, 32 pulse-distance bits,
//               stop burst and gap; demodulated and carrier-modulated outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module ir_nec_tx #(
    parameter int TICK_DIV     = ir_nec_pkg::TICK_DIV,
    parameter int LEAD_MARK    = ir_nec_pkg::LEAD_MARK,
    parameter int LEAD_SPACE   = ir_nec_pkg::LEAD_SPACE,
    parameter int BIT_MARK     = ir_nec_pkg::BIT_MARK,
    parameter int ZERO_SPACE   = ir_nec_pkg::ZERO_SPACE,
    parameter int ONE_SPACE    = ir_nec_pkg::ONE_SPACE,
    parameter int GAP_TICKS    = ir_nec_pkg::GAP_TICKS,
    parameter int CARRIER_HALF = ir_nec_pkg::CARRIER_HALF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] cmd,
    output logic       busy,
    output logic       done,
    output logic       ir_out,
    output logic       ir_led
);

    import ir_nec_pkg::*;

    localparam int c_SEG_W = SEG_W;
    localparam logic [c_SEG_W-1:0] c_LEAD_M_LAST = c_SEG_W'(LEAD_MARK - 1);
    localparam logic [c_SEG_W-1:0] c_LEAD_S_LAST = c_SEG_W'(LEAD_SPACE - 1);
    localparam logic [c_SEG_W-1:0] c_MARK_LAST   = c_SEG_W'(BIT_MARK - 1);
    localparam logic [c_SEG_W-1:0] c_ZERO_LAST   = c_SEG_W'(ZERO_SPACE - 1);
    localparam logic [c_SEG_W-1:0] c_ONE_LAST    = c_SEG_W'(ONE_SPACE - 1);
    localparam logic [c_SEG_W-1:0] c_GAP_LAST    = c_SEG_W'(GAP_TICKS - 1);
    localparam int c_CAR_W = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam logic [c_CAR_W-1:0] c_CAR_LAST    = c_CAR_W'(CARRIER_HALF - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [31:0]          r_shreg;
    logic [5:0]           r_bitcnt;
    logic [c_SEG_W-1:0]   r_segcnt;
    logic [c_SEG_W-1:0]   w_seg_last;
    logic                 w_tick;
    logic                 w_seg_end;
    logic                 w_accept;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_ir_out;
    logic                 w_busy_d;
    logic                 w_done_d;
    logic                 w_ir_d;
    logic [c_CAR_W-1:0]   r_car_cnt;
    logic                 r_car;

    ir_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (r_state == c_ST_IDLE),
        .tick (w_tick)
    );

    // A start coinciding with the done pulse waits for the following cycle
    assign w_accept  = (r_state == c_ST_IDLE) && start && !r_done;
    assign w_seg_end = (r_state != c_ST_IDLE) && w_tick && (r_segcnt == w_seg_last);

    always_comb begin
        w_seg_last = '0;
        case (r_state)
            c_ST_LEAD_M: w_seg_last = c_LEAD_M_LAST;
            c_ST_LEAD_S: w_seg_last = c_LEAD_S_LAST;
            c_ST_BIT_M:  w_seg_last = c_MARK_LAST;
            c_ST_BIT_S:  w_seg_last = r_shreg[31] ? c_ONE_LAST : c_ZERO_LAST;
            c_ST_STOP_M: w_seg_last = c_MARK_LAST;
            c_ST_GAP:    w_seg_last = c_GAP_LAST;
            default:     w_seg_last = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_accept)  w_next_state = c_ST_LEAD_M;
            c_ST_LEAD_M: if (w_seg_end) w_next_state = c_ST_LEAD_S;
            c_ST_LEAD_S: if (w_seg_end) w_next_state = c_ST_BIT_M;
            c_ST_BIT_M:  if (w_seg_end) w_next_state = c_ST_BIT_S;
            c_ST_BIT_S:  if (w_seg_end) w_next_state = (r_bitcnt == 6'(FRAME_BITS - 1))
                                                       ? c_ST_STOP_M : c_ST_BIT_M;
            c_ST_STOP_M: if (w_seg_end) w_next_state = c_ST_GAP;
            c_ST_GAP:    if (w_seg_end) w_next_state = c_ST_IDLE;
            default:                    w_next_state = c_ST_IDLE;
        endcase
    end

    // busy drops together with the done pulse as the FSM re-enters IDLE
    always_comb begin
        w_done_d = (r_state == c_ST_GAP) && w_seg_end;
        w_busy_d = (r_state != c_ST_IDLE) && !w_done_d;
        w_ir_d   = (r_state == c_ST_LEAD_M) || (r_state == c_ST_BIT_M) ||
                   (r_state == c_ST_STOP_M);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ir_out <= 1'b0;
        end else begin
            r_busy   <= w_busy_d;
            r_done   <= w_done_d;
            r_ir_out <= w_ir_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_segcnt <= '0;
        end else if (w_accept) begin
            r_shreg  <= nec_frame(addr, cmd);
            r_bitcnt <= '0;
            r_segcnt <= '0;
        end else if (r_state != c_ST_IDLE) begin
            if (w_seg_end) begin
                r_segcnt <= '0;
                if (r_state == c_ST_BIT_S) begin
                    r_shreg  <= {r_shreg[30:0], 1'b0};
                    r_bitcnt <= r_bitcnt + 1'b1;
                end
            end else if (w_tick) begin
                r_segcnt <= r_segcnt + 1'b1;
            end
        end
    end

    // Carrier phase is held at "high, count 0" outside marks
    always_ff @(posedge clk) begin
        if (!rst || !r_ir_out) begin
            r_car_cnt <= '0;
            r_car     <= 1'b1;
        end else if (r_car_cnt == c_CAR_LAST) begin
            r_car_cnt <= '0;
            r_car     <= ~r_car;
        end else begin
            r_car_cnt <= r_car_cnt + 1'b1;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign ir_out = r_ir_out;
    assign ir_led = r_ir_out & r_car;

endmodule
`default_nettype wire
